systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Edge driver for the INT8 systolic multiply array: it accepts one row-vector beat and one column-vector beat per transaction and launches them into the west and north edges of the PE grid. Lane i is delayed by i cycles (diagonal skew), so that A[r][k] and B[k][c] meet in PE(r,c) on the same cycle. After the last beat it injects zero bubbles until the farthest PE has accumulated. It then asserts the freeze (complete_flag) that all PEs share, so the accumulated sums hold for readout.

## Interface
- N, 4, array dimension; number of row lanes and column lanes
- DW, 16, per-lane element width (matches PE west/north port width)
- KW, 16, width of the k_len transaction length
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin transaction; sampled only in IDLE
- k_len  input  KW  number of beats (inner dimension K); sampled with start
- in_valid  input  1  beat present on in_row/in_col
- in_ready  output  1  feeder accepts a beat this cycle
- in_row  input  N*DW  lane r = bits [r*DW +: DW], element A[r][k]
- in_col  input  N*DW  lane c = bits [c*DW +: DW], element B[k][c]
- west_row_out  output  N*DW  skewed row lanes to PE(r,0)
- north_col_out  output  N*DW  skewed column lanes to PE(0,c)
- complete_flag  output  1  array freeze; high = PEs hold state
- busy  output  1  high in LOAD and DRAIN
- done  output  1  one-cycle pulse when the transaction finishes

## Operation
- States are IDLE, LOAD and DRAIN. The registers are the state, beat counter (KW bits), drain counter (clog2(2N) bits) and per-lane skew shift registers.
- IDLE: complete_flag=1, in_ready=0, busy=0.
  - start=1 and k_len>0 → LOAD; the beat counter is loaded with k_len.
  - start=1 and k_len=0 → stay in IDLE; done pulses the next cycle and nothing is emitted.
- LOAD: complete_flag=0, in_ready=1, busy=1.
  - A beat is accepted when in_valid && in_ready; the beat counter decrements.
  - Acceptance of the final beat (counter==1) → DRAIN; the drain counter is loaded with 2N-1.
- DRAIN: complete_flag=0, in_ready=0, busy=1.
  - The drain counter decrements every cycle.
  - At counter==1 → IDLE and done=1 on the following cycle; complete_flag rises on that same edge.
- Skew, lane i (rows and columns identical):
  - The lane-i stage-0 register captures the accepted element, or zero when no beat is accepted.
  - The lane-i output is its stage-i register.
  - Lane 0 has one register; lane N-1 has N registers.
- Bubbles: a stall cycle (in_valid=0 in LOAD) and every DRAIN cycle inject zero on all lanes in the same slot. The product of misaligned data in a PE is therefore always zero, and stalls never corrupt sums.
- The skew registers shift in every state, including IDLE, where they flush with zeros.
- start while busy is ignored. in_valid outside LOAD is ignored and the data is not captured.
- No arithmetic is performed. Data passes bit-exact; signedness is the consumer's concern.

## Timing
- Reset (async, immediate):
  - state=IDLE; all skew registers=0.
  - west_row_out=0, north_col_out=0.
  - complete_flag=1, in_ready=0, busy=0, done=0.
- start is sampled at edge S; in_ready and busy are high from cycle S+1 and complete_flag is low from S+1.
- A beat accepted at edge T appears on west_row_out/north_col_out lane i during cycle T+1+i. That element reaches PE(r,c) during cycle T+1+r+c.
- Final beat accepted at edge T: DRAIN covers cycles T+1 .. T+2N-1. complete_flag=1 and done=1 from edge T+2N-1 (visible in cycle T+2N), giving the last PE its accumulate edge at T+2N-1.
- in_ready is a registered state decode, not combinational on in_valid.
- Reset asserted mid-LOAD or mid-DRAIN aborts immediately: no done pulse, and complete_flag returns to 1.
- start in the same cycle that done is high is accepted, because the state is already IDLE.

## Test plan
- N=4, k_len=3, in_valid held high, beat values 1,2,3 on every lane:
  - lane i shows 1,2,3 starting at cycle S+2+i;
  - in_ready is high for exactly 3 cycles;
  - done and complete_flag rise 7 cycles after the third acceptance.
- Same as above but in_valid=0 for 2 cycles after beat 1:
  - every lane shows 1,0,0,2,3 at the correct skew;
  - done is delayed by exactly 2 cycles.
- start with k_len=0 → done pulses one cycle later; busy and in_ready never rise; outputs stay 0.
- Reset mid-LOAD after 2 of 5 beats:
  - all outputs are 0 and complete_flag=1 immediately;
  - a new start with k_len=2 completes normally.
- start pulsed during LOAD and DRAIN → no effect on counters. A back-to-back start coincident with done → a new LOAD begins the next cycle.
- Integration with a 4x4 PE grid, A=I and B=[1..16]: after done, PE(r,c) holds B[r][c]; the sums stay frozen while complete_flag=1.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: transaction inputs and skewed west/north edge outputs of the systolic feeder.
interface systolic_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int KW = 16
);
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_row;
  logic [N*DW-1:0] in_col;
  logic [N*DW-1:0] west_row_out;
  logic [N*DW-1:0] north_col_out;
  logic            complete_flag;
  logic            busy;
  logic            done;
  modport master (
    output start, k_len, in_valid, in_row, in_col,
    input  in_ready, west_row_out, north_col_out, complete_flag, busy, done
  );
  modport slave (
    input  start, k_len, in_valid, in_row, in_col,
    output in_ready, west_row_out, north_col_out, complete_flag, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews row/column beats diagonally into a PE grid, drains with zero bubbles,
// then raises the shared freeze so accumulated sums hold for readout.
module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int KW = 16
) (
  input logic clk,
  input logic rst_n,
  systolic_feeder_if.slave bus
);
  localparam int CW = $clog2(2 * N);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t        state, state_d;
  logic [KW-1:0] beat, beat_d;
  logic [CW-1:0] drain, drain_d;
  logic          done_q, done_d;
  logic          accept;
  assign accept            = state == LOAD && bus.in_valid;
  assign bus.in_ready      = state == LOAD;
  assign bus.busy          = state != IDLE;
  assign bus.complete_flag = state == IDLE;
  assign bus.done          = done_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      beat   <= '0;
      drain  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      beat   <= beat_d;
      drain  <= drain_d;
      done_q <= done_d;
    end
  always_comb begin
    state_d = state;
    beat_d  = beat;
    drain_d = drain;
    done_d  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_d = bus.k_len == '0 ? IDLE : LOAD;
        beat_d  = bus.k_len;
        done_d  = bus.k_len == '0;
      end
      LOAD: if (accept) begin
        beat_d = beat - 1'b1;
        if (beat == KW'(1)) begin
          state_d = DRAIN;
          drain_d = CW'(2 * N - 1);
        end
      end
      DRAIN: begin
        drain_d = drain - 1'b1;
        if (drain == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Lane i is an (i+1)-deep shift chain; non-accepted slots inject zeros so misaligned products vanish.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] r_sr [i+1];
    logic [DW-1:0] c_sr [i+1];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) begin
          r_sr[j] <= '0;
          c_sr[j] <= '0;
        end
      end else begin
        r_sr[0] <= accept ? bus.in_row[i*DW +: DW] : '0;
        c_sr[0] <= accept ? bus.in_col[i*DW +: DW] : '0;
        for (int j = 1; j <= i; j++) begin
          r_sr[j] <= r_sr[j-1];
          c_sr[j] <= c_sr[j-1];
        end
      end
    assign bus.west_row_out[i*DW +: DW]  = r_sr[i];
    assign bus.north_col_out[i*DW +: DW] = c_sr[i];
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: transaction/time-level model with per-cycle compare, directed scenarios and a PE grid.
module tb_systolic_feeder;
  localparam int N = 4, DW = 16, KW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  systolic_feeder_if #(.N(N), .DW(DW), .KW(KW)) bus ();
  systolic_feeder #(.N(N), .DW(DW), .KW(KW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, failures = 0, cyc = 0, rst_cyc = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask
  // cyc = number of rising edges seen; "cycle X" is the low phase with cyc==X
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_cyc = cyc;
  // Model: beat slots by edge index, plus timing-based control expectations
  logic [N*DW-1:0] hist_r [64];
  logic [N*DW-1:0] hist_c [64];
  logic m_load, m_busy, m_done;
  int   m_beats, m_end;
  always @(posedge clk) begin
    hist_r[cyc % 64] <= (rst_n && m_load && bus.in_valid) ? bus.in_row : '0;
    hist_c[cyc % 64] <= (rst_n && m_load && bus.in_valid) ? bus.in_col : '0;
  end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_load <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_beats <= 0; m_end <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && bus.start) begin
        if (bus.k_len == 0) m_done <= 1'b1;
        else begin m_load <= 1'b1; m_busy <= 1'b1; m_beats <= int'(bus.k_len); end
      end else if (m_load && bus.in_valid) begin
        m_beats <= m_beats - 1;
        if (m_beats == 1) begin m_load <= 1'b0; m_end <= cyc + 2 * N - 1; end
      end else if (m_busy && !m_load && cyc == m_end) begin
        m_busy <= 1'b0; m_done <= 1'b1;
      end
    end
  logic [DW-1:0] wlog [N][1024];
  logic done_log [1024], cf_log [1024], ready_log [1024], busy_log [1024];
  logic [N*DW-1:0] hr, hc;
  always @(negedge clk) begin
    if (cyc < 1024) begin
      for (int i = 0; i < N; i++) wlog[i][cyc] <= bus.west_row_out[i*DW +: DW];
      done_log[cyc] <= bus.done; cf_log[cyc] <= bus.complete_flag;
      ready_log[cyc] <= bus.in_ready; busy_log[cyc] <= bus.busy;
    end
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = cyc - 1 - i;
      hr = idx >= rst_cyc ? hist_r[idx % 64] : '0;
      hc = idx >= rst_cyc ? hist_c[idx % 64] : '0;
      chk($sformatf("west_lane%0d", i), 64'(bus.west_row_out[i*DW +: DW]), 64'(hr[i*DW +: DW]));
      chk($sformatf("north_lane%0d", i), 64'(bus.north_col_out[i*DW +: DW]), 64'(hc[i*DW +: DW]));
    end
    chk("in_ready", 64'(bus.in_ready), 64'(m_load));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("complete_flag", 64'(bus.complete_flag), 64'(!m_busy));
    chk("done", 64'(bus.done), 64'(m_done));
  end
  // Behavioural 4x4 output-stationary PE grid driven by the feeder edges
  int acc [N][N];
  logic [DW-1:0] ga [N][N], gb [N][N];
  logic grid_clr = 1'b0;
  function automatic logic [DW-1:0] a_in(input int r, input int c);
    return c == 0 ? bus.west_row_out[r*DW +: DW] : ga[r][c-1];
  endfunction
  function automatic logic [DW-1:0] b_in(input int r, input int c);
    return r == 0 ? bus.north_col_out[c*DW +: DW] : gb[r-1][c];
  endfunction
  always @(posedge clk)
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ga[r][c] <= rst_n ? a_in(r, c) : '0;
        gb[r][c] <= rst_n ? b_in(r, c) : '0;
        acc[r][c] <= grid_clr ? 0 :
                     (rst_n && !bus.complete_flag) ? acc[r][c] + int'(a_in(r, c)) * int'(b_in(r, c)) : acc[r][c];
      end
  function automatic logic [N*DW-1:0] rep(input int v);
    logic [N*DW-1:0] x;
    for (int i = 0; i < N; i++) x[i*DW +: DW] = DW'(v);
    return x;
  endfunction
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic go(input int k, output int s);
    s = cyc;
    bus.start = 1'b1; bus.k_len = KW'(k);
    tick();
    bus.start = 1'b0;
  endtask
  // value 0 means a stall slot; stalled data is garbage that must never be captured
  task automatic feed(input int v [5], input int n);
    for (int j = 0; j < n; j++) begin
      bus.in_valid = v[j] != 0;
      bus.in_row = rep(v[j] != 0 ? v[j] : 16'hdead);
      bus.in_col = rep(v[j] != 0 ? v[j] << 4 : 16'hbeef);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask
  initial begin
    int s, seq [5], cnt;
    bit seen;
    bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0; bus.in_row = '0; bus.in_col = '0;
    repeat (2) tick();
    chk("rst_complete", 64'(bus.complete_flag), 64'd1);
    chk("rst_west", 64'(bus.west_row_out), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    // 1: three back-to-back beats
    go(3, s);
    feed('{1, 2, 3, 0, 0}, 3);
    repeat (12) tick();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++) chk("t1_skew", 64'(wlog[i][s+2+i+j]), 64'(j + 1));
    cnt = 0;
    for (int t = s; t <= s + 12; t++) cnt += int'(ready_log[t]);
    chk("t1_ready_cycles", 64'(cnt), 64'd3);
    chk("t1_done_before", 64'(done_log[s+10]), 64'd0);
    chk("t1_done", 64'(done_log[s+11]), 64'd1);
    chk("t1_cf_before", 64'(cf_log[s+10]), 64'd0);
    chk("t1_cf", 64'(cf_log[s+11]), 64'd1);
    // 2: two stall cycles after beat 1
    go(3, s);
    feed('{1, 0, 0, 2, 3}, 5);
    repeat (12) tick();
    seq = '{1, 0, 0, 2, 3};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 5; j++) chk("t2_skew", 64'(wlog[i][s+2+i+j]), 64'(seq[j]));
    chk("t2_done_before", 64'(done_log[s+12]), 64'd0);
    chk("t2_done", 64'(done_log[s+13]), 64'd1);
    // 3: zero-length transaction
    go(0, s);
    repeat (5) tick();
    chk("t3_done", 64'(done_log[s+1]), 64'd1);
    chk("t3_done_once", 64'(done_log[s+2]), 64'd0);
    cnt = 0;
    for (int t = s; t <= s + 5; t++) cnt += int'(busy_log[t]) + int'(ready_log[t]) + int'(wlog[0][t] != 0);
    chk("t3_quiet", 64'(cnt), 64'd0);
    // 4: reset mid-LOAD after 2 of 5 beats
    go(5, s);
    feed('{1, 2, 0, 0, 0}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_west", 64'(bus.west_row_out), 64'd0);
    chk("t4_north", 64'(bus.north_col_out), 64'd0);
    chk("t4_cf", 64'(bus.complete_flag), 64'd1);
    chk("t4_busy", 64'({bus.busy, bus.in_ready, bus.done}), 64'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    go(2, s);
    feed('{5, 6, 0, 0, 0}, 2);
    repeat (10) tick();
    chk("t4_restart_lane0", 64'(wlog[0][s+2]), 64'd5);
    chk("t4_restart_done", 64'(done_log[s+10]), 64'd1);
    // 5: start pulsed during LOAD and DRAIN, then back-to-back start on done
    go(2, s);
    bus.start = 1'b1; bus.k_len = 9; bus.in_valid = 1'b1; bus.in_row = rep(7); bus.in_col = rep(7);
    tick();
    bus.start = 1'b0; bus.in_row = rep(8); bus.in_col = rep(8);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b1; bus.k_len = 4;
    tick();
    bus.start = 1'b0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) if (bus.done) seen = 1; else tick();
    chk("t5_done_seen", 64'(seen), 64'd1);
    chk("t5_done_cycle", 64'(cyc), 64'(s + 10));
    s = cyc;
    bus.start = 1'b1; bus.k_len = 1;
    tick();
    bus.start = 1'b0;
    chk("t5_b2b_ready", 64'(bus.in_ready), 64'd1);
    feed('{9, 0, 0, 0, 0}, 1);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) if (bus.done) seen = 1; else tick();
    chk("t5_b2b_done_seen", 64'(seen), 64'd1);
    chk("t5_b2b_done_cycle", 64'(cyc), 64'(s + 9));
    // 6: A = identity, B = 1..16 through the PE grid
    grid_clr = 1'b1;
    tick();
    grid_clr = 1'b0;
    go(4, s);
    for (int k = 0; k < N; k++) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        bus.in_row[i*DW +: DW] = DW'(i == k);
        bus.in_col[i*DW +: DW] = DW'(k * N + i + 1);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (10) tick();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) chk($sformatf("t6_pe%0d%0d", r, c), 64'(acc[r][c]), 64'(r * N + c + 1));
    repeat (5) tick();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) chk($sformatf("t6_frozen%0d%0d", r, c), 64'(acc[r][c]), 64'(r * N + c + 1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end
endmodule
